// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose
//   Parametrised hazard unit for the pipelined ARM core. A DEPTH-entry shift
//   register records the register writes in flight, with entry 0 = Execute and
//   entry DEPTH-1 = Writeback. From these entries the unit derives:
//   - decode-stage load-use and ALU stalls (combinational), and
//   - registered Execute-stage operand forwarding selects.
//
// Parameters
//   NREG        architectural register count (AW = $clog2(NREG))
//   DEPTH       tracked stages from E to W inclusive, >= 2 (FW = $clog2(DEPTH))
//   ALU_STAGE   first entry index from which an ALU result can be forwarded
//   LOAD_STAGE  first entry index from which a load result can be forwarded
//   PC_IDX      register index whose reads never hazard (PC)
//
// Ports
//   clk, reset        core clock; asynchronous active-high reset
//   valid_d           Decode holds a real instruction
//   ra1_d/use1_d      Decode source A index / source A is read
//   ra2_d/use2_d      Decode source B index / source B is read
//   wa_d/we_d/load_d  Decode destination / writes a register / is a load
//   flush_d           kill the Decode instruction; it enters E as a bubble
//   hold              memory back-pressure; freezes all state
//   stall_f/stall_d   freeze PC / freeze Decode register
//   fwd_a_e/fwd_b_e   E operand select: 0 = regfile, k = result of entry k
//   stall_cnt/fwd_cnt performance counters (HAZARD_SCOREBOARD_PERF_EN only)
//
// Configuration
//   HAZARD_SCOREBOARD_PERF_EN  when defined, adds the saturating stall_cnt and
//                              fwd_cnt counters; otherwise they do not exist.
//
// Decode handshake
//   valid_d qualifies the Decode instruction. It advances into E on a clock
//   edge only when valid_d=1 and stall_d=0; with flush_d=1 or stall_d=1 a
//   bubble enters E instead. stall_d=1 means "not ready": Decode must present
//   the same instruction again on the next cycle.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG       = 16,
  parameter int DEPTH      = 3,
  parameter int ALU_STAGE  = 1,
  parameter int LOAD_STAGE = 2,
  parameter int PC_IDX     = 15,
  localparam int AW        = $clog2(NREG),
  localparam int FW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_d,
  input  logic [AW-1:0] ra1_d,
  input  logic          use1_d,
  input  logic [AW-1:0] ra2_d,
  input  logic          use2_d,
  input  logic [AW-1:0] wa_d,
  input  logic          we_d,
  input  logic          load_d,
  input  logic          flush_d,
  input  logic          hold,
  output logic          stall_f,
  output logic          stall_d,
  output logic [FW-1:0] fwd_a_e,
  output logic [FW-1:0] fwd_b_e
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   fwd_cnt
`endif
);

  typedef struct packed {
    logic          hit;  // some tracked entry writes this source
    logic          haz;  // the governing entry cannot forward in time
    logic [FW-1:0] sel;  // forward target index (entry index after advance)
  } match_t;

  // In-flight write entries {v, wa, ld}
  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_ld;
  logic [AW-1:0]    r_wa [DEPTH];

  logic [FW-1:0]    r_fwd_a;
  logic [FW-1:0]    r_fwd_b;

  match_t           w_ma;
  match_t           w_mb;
  logic             w_haz;
  logic             w_adv;
  logic             w_new_v;
  logic [FW-1:0]    w_fwd_a_nxt;
  logic [FW-1:0]    w_fwd_b_nxt;

  // Scan from oldest to youngest so the youngest match is the one that
  // sticks: its value is the architecturally current one. The writeback
  // entry is skipped because the register file writes in the first half
  // cycle and reads in the second.
  function automatic match_t lookup(
    input logic             en,
    input logic [AW-1:0]    ra,
    input logic [DEPTH-1:0] v,
    input logic [DEPTH-1:0] ld,
    input logic [AW-1:0]    wa [DEPTH]
  );
    match_t m;
    m = '0;
    if (en) begin
      for (int i = DEPTH - 2; i >= 0; i--) begin
        if (v[i] && (wa[i] == ra)) begin
          m.hit = 1'b1;
          // The instruction in Decode reaches E one edge later, by which time
          // entry i has moved to i+1.
          m.sel = FW'(i + 1);
          m.haz = ld[i] ? ((i + 1) < LOAD_STAGE) : ((i + 1) < ALU_STAGE);
        end
      end
    end
    return m;
  endfunction

  always_comb begin
    w_ma = lookup(use1_d && valid_d && (ra1_d != AW'(PC_IDX)), ra1_d, r_v, r_ld, r_wa);
    w_mb = lookup(use2_d && valid_d && (ra2_d != AW'(PC_IDX)), ra2_d, r_v, r_ld, r_wa);
  end

  assign w_haz   = w_ma.haz | w_mb.haz;
  // Decode really moves into E this edge (hold is handled by the freeze).
  assign w_adv   = valid_d & ~w_haz & ~flush_d;
  assign w_new_v = w_adv & we_d;

  assign w_fwd_a_nxt = (w_ma.hit && w_adv) ? w_ma.sel : '0;
  assign w_fwd_b_nxt = (w_mb.hit && w_adv) ? w_mb.sel : '0;

  // Reset gates the stall so the outputs read 0 at once, even while hold=1.
  assign stall_d = ~reset & (w_haz | hold);
  assign stall_f = stall_d;
  assign fwd_a_e = r_fwd_a;
  assign fwd_b_e = r_fwd_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v     <= '0;
      r_ld    <= '0;
      r_fwd_a <= '0;
      r_fwd_b <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_wa[i] <= '0;
      end
    end else if (!hold) begin
      r_v     <= {r_v[DEPTH-2:0], w_new_v};
      r_ld    <= {r_ld[DEPTH-2:0], load_d};
      r_wa[0] <= wa_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_wa[i] <= r_wa[i-1];
      end
      r_fwd_a <= w_fwd_a_nxt;
      r_fwd_b <= w_fwd_b_nxt;
    end
  end

  // The writeback entry only exists to mark the retiring write; nothing
  // downstream of the scoreboard reads it.
  logic w_unused_retire;
  assign w_unused_retire = ^{r_v[DEPTH-1], r_ld[DEPTH-1], r_wa[DEPTH-1]};

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;
  logic [1:0]  w_fwd_inc;
  logic [32:0] w_fwd_sum;

  assign w_fwd_inc = {1'b0, |w_fwd_a_nxt} + {1'b0, |w_fwd_b_nxt};
  assign w_fwd_sum = {1'b0, r_fwd_cnt} + 33'(w_fwd_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (!hold) begin
      if (w_haz && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      r_fwd_cnt <= w_fwd_sum[32] ? 32'hFFFF_FFFF : w_fwd_sum[31:0];
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard (DEPTH=3, ALU_STAGE=1, LOAD_STAGE=2).
// The driver applies one Decode instruction per cycle at posedge+1 and pushes
// the expected {stall_f, stall_d, fwd_a_e, fwd_b_e} for that cycle; the
// monitor pops and compares at every negedge while expectations are pending.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int AW = 4;
  localparam int FW = 2;
  localparam int W  = 2 + 2 * FW;

  logic          clk;
  logic          reset;
  logic          valid_d;
  logic [AW-1:0] ra1_d;
  logic          use1_d;
  logic [AW-1:0] ra2_d;
  logic          use2_d;
  logic [AW-1:0] wa_d;
  logic          we_d;
  logic          load_d;
  logic          flush_d;
  logic          hold;
  logic          stall_f;
  logic          stall_d;
  logic [FW-1:0] fwd_a_e;
  logic [FW-1:0] fwd_b_e;
`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   fwd_cnt;
`endif

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp;
  int           n_err;

  hazard_scoreboard #(
    .NREG(16), .DEPTH(3), .ALU_STAGE(1), .LOAD_STAGE(2), .PC_IDX(15)
  ) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d),
    .ra1_d(ra1_d), .use1_d(use1_d), .ra2_d(ra2_d), .use2_d(use2_d),
    .wa_d(wa_d), .we_d(we_d), .load_d(load_d), .flush_d(flush_d),
    .hold(hold), .stall_f(stall_f), .stall_d(stall_d),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
`ifdef HAZARD_SCOREBOARD_PERF_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act[W-1:0], exp[W-1:0]);
    end
  endtask

  task automatic chk_cnt(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents stall/forward outputs.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, 64'({stall_f, stall_d, fwd_a_e, fwd_b_e}), 64'(e));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int v, input int a1, input int u1, input int a2, input int u2,
                       input int wa, input int we, input int ld, input int fl, input int hd,
                       input int s, input int fa, input int fb, input string nm);
    @(posedge clk);
    #1;
    valid_d = (v != 0);
    ra1_d   = AW'(a1);
    use1_d  = (u1 != 0);
    ra2_d   = AW'(a2);
    use2_d  = (u2 != 0);
    wa_d    = AW'(wa);
    we_d    = (we != 0);
    load_d  = (ld != 0);
    flush_d = (fl != 0);
    hold    = (hd != 0);
    exp_q.push_back({1'(s), 1'(s), FW'(fa), FW'(fb)});
    name_q.push_back(nm);
  endtask

  task automatic idle(input int s, input int fa, input int fb, input string nm);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s, fa, fb, nm);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) idle(0, 0, 0, "drain");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; valid_d = 1'b0; ra1_d = '0; use1_d = 1'b0; ra2_d = '0; use2_d = 1'b0;
    wa_d = '0; we_d = 1'b0; load_d = 1'b0; flush_d = 1'b0; hold = 1'b0;
    #2;
    chk("reset_state", 64'({stall_f, stall_d, fwd_a_e, fwd_b_e}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Load-use: LDR r2 ; ADD r4,r2,r2 -> one stall, then both operands from entry 2
    drive(1, 0, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, "lu_ldr");
    drive(1, 2, 1, 2, 1, 4, 1, 0, 0, 0, 1, 0, 0, "lu_stall");
    drive(1, 2, 1, 2, 1, 4, 1, 0, 0, 0, 0, 0, 0, "lu_release");
    idle(0, 2, 2, "lu_fwd");
`ifdef HAZARD_SCOREBOARD_PERF_EN
    chk_cnt("lu_stall_cnt", stall_cnt, 32'd1);
    chk_cnt("lu_fwd_cnt", fwd_cnt, 32'd2);
`endif
    drain();

    // ALU forward: ADD r1,r2,r3 ; SUB r2,r1,r3 -> no stall, fwd_a=1
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0, "alu_add");
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0, "alu_sub");
    idle(0, 1, 0, "alu_fwd");
    drain();

    // Youngest wins: MOV r3 ; ADD r3 ; ORR r5,r3,r6 -> fwd_a=1, not 2
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, "yw_mov");
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, "yw_add");
    drive(1, 3, 1, 6, 1, 5, 1, 0, 0, 0, 0, 0, 0, "yw_orr");
    idle(0, 1, 0, "yw_fwd");
    drain();

    // Youngest load over older ALU write of r3 -> stall, then fwd_a=2
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, "yl_add");
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, "yl_ldr");
    drive(1, 3, 1, 0, 0, 11, 1, 0, 0, 0, 1, 0, 0, "yl_stall");
    drive(1, 3, 1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0, "yl_go");
    idle(0, 2, 0, "yl_fwd");
    drain();

    // PC source: load into r15 then read r15 twice -> no stall, no forward
    drive(1, 0, 0, 0, 0, 15, 1, 1, 0, 0, 0, 0, 0, "pc_ldr");
    drive(1, 15, 1, 15, 1, 7, 1, 0, 0, 0, 0, 0, 0, "pc_read");
    idle(0, 0, 0, "pc_fwd");
    drain();

    // Flushed writer leaves no entry behind
    drive(1, 0, 0, 0, 0, 8, 1, 1, 1, 0, 0, 0, 0, "fl_wr");
    drive(1, 8, 1, 8, 1, 12, 1, 0, 0, 0, 0, 0, 0, "fl_read");
    idle(0, 0, 0, "fl_fwd");
    drain();

    // Flush together with a load-use hazard: stall still asserted
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, "fh_ldr");
    drive(1, 9, 1, 0, 0, 13, 1, 0, 1, 0, 1, 0, 0, "fh_stall");
    idle(0, 0, 0, "fh_fwd");
    drain();

    // Flushed reader with an ALU match captures select 0
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, "fa_add");
    drive(1, 10, 1, 10, 1, 14, 1, 0, 1, 0, 0, 0, 0, "fa_flush");
    idle(0, 0, 0, "fa_fwd");
    drain();

    // Hold during load-use: state and selects frozen, stall forced high
    drive(1, 0, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, "ho_ldr");
    drive(1, 2, 1, 2, 1, 4, 1, 0, 0, 1, 1, 0, 0, "ho_hold_haz");
    drive(1, 2, 1, 2, 1, 4, 1, 0, 0, 0, 1, 0, 0, "ho_stall");
    drive(1, 2, 1, 2, 1, 4, 1, 0, 0, 0, 0, 0, 0, "ho_go");
    drive(1, 4, 1, 0, 0, 6, 1, 0, 0, 1, 1, 2, 2, "ho_hold1");
    drive(1, 4, 1, 0, 0, 6, 1, 0, 0, 1, 1, 2, 2, "ho_hold2");
    drive(1, 4, 1, 0, 0, 6, 1, 0, 0, 1, 1, 2, 2, "ho_hold3");
    drive(1, 4, 1, 0, 0, 6, 1, 0, 0, 0, 0, 2, 2, "ho_resume");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, "rst_hold");
`ifdef HAZARD_SCOREBOARD_PERF_EN
    chk_cnt("pre_rst_stall_cnt", stall_cnt, 32'd4);
    chk_cnt("pre_rst_fwd_cnt", fwd_cnt, 32'd8);
`endif

    // Reset asserted mid-hold, between clock edges
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_outputs", 64'({stall_f, stall_d, fwd_a_e, fwd_b_e}), 64'd0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
    chk_cnt("rst_stall_cnt", stall_cnt, 32'd0);
    chk_cnt("rst_fwd_cnt", fwd_cnt, 32'd0);
`endif
    hold = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Entries were cleared: reading r4 no longer matches
    drive(1, 4, 1, 2, 1, 6, 1, 0, 0, 0, 0, 0, 0, "post_rst");
    idle(0, 0, 0, "post_rst_fwd");

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
